// File: rtl/max7219_frame_monitor.sv
// Passive snoop of the MAX7219 SPI stream: deserialises 16-bit frames, flags malformed ones,
// and mirrors the register file. Optional macro MAX7219_MONITOR_ERR_COUNT_EN adds an error counter.
module max7219_frame_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_serial_clk,
  input  logic       i_serial_dout,
  input  logic       i_serial_load,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_frame_stb,
  output logic [3:0] o_frame_addr,
  output logic [7:0] o_frame_data,
  output logic       o_frame_err,
  output logic [7:0] o_frame_count,
  output logic       o_shutdown_n,
  output logic [7:0] o_err_count
);

  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] BIT_SAT    = 5'd17;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] dout_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   sck_prev;
  logic                   load_prev;

  logic sck_s, dout_s, load_s;
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign dout_s = dout_sync[SYNC_STAGES-1];
  assign load_s = load_sync[SYNC_STAGES-1];

  // Synchroniser chains; LOAD idles high so reset never fabricates a falling edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sck_sync  <= '0;
      dout_sync <= '0;
      load_sync <= '1;
      sck_prev  <= 1'b0;
      load_prev <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_serial_clk};
      dout_sync <= {dout_sync[SYNC_STAGES-2:0], i_serial_dout};
      load_sync <= {load_sync[SYNC_STAGES-2:0], i_serial_load};
      sck_prev  <= sck_s;
      load_prev <= load_s;
    end
  end

  // Stage p0: registered edge events aligned with the sampled data bit
  logic sck_rise_p0, load_rise_p0, load_fall_p0, load_lvl_p0, dout_p0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sck_rise_p0  <= 1'b0;
      load_rise_p0 <= 1'b0;
      load_fall_p0 <= 1'b0;
      load_lvl_p0  <= 1'b1;
      dout_p0      <= 1'b0;
    end else begin
      sck_rise_p0  <= sck_s & ~sck_prev;
      load_rise_p0 <= load_s & ~load_prev;
      load_fall_p0 <= ~load_s & load_prev;
      load_lvl_p0  <= load_s;
      dout_p0      <= dout_s;
    end
  end

  // Stage p1: deserialiser. Only the low 12 frame bits carry addr/data, so only those are kept.
  logic [11:0] shift_reg;
  logic [4:0]  bit_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load_fall_p0) begin
      bit_cnt <= '0;
    end else if (sck_rise_p0 && !load_lvl_p0) begin
      shift_reg <= {shift_reg[10:0], dout_p0};
      bit_cnt   <= (bit_cnt == BIT_SAT) ? BIT_SAT : bit_cnt + 5'd1;
    end
  end

  logic       commit_ok, commit_bad, shadow_we;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign commit_ok  = load_rise_p0 && (bit_cnt == FRAME_BITS);
  assign commit_bad = load_rise_p0 && (bit_cnt != FRAME_BITS);
  assign wr_addr    = shift_reg[11:8];
  assign wr_data    = shift_reg[7:0];
  assign shadow_we  = commit_ok && (wr_addr != 4'h0);

  // Stage p2: frame result outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_frame_stb   <= 1'b0;
      o_frame_err   <= 1'b0;
      o_frame_addr  <= '0;
      o_frame_data  <= '0;
      o_frame_count <= '0;
    end else begin
      o_frame_stb <= commit_ok;
      o_frame_err <= commit_bad;
      if (commit_ok) begin
        o_frame_addr  <= wr_addr;
        o_frame_data  <= wr_data;
        o_frame_count <= o_frame_count + 8'd1;
      end
    end
  end

  logic [7:0] shadow [16];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (shadow_we) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Write-first readback: a same-cycle write to the read address is forwarded.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_data <= '0;
    end else if (shadow_we && (wr_addr == i_rd_addr)) begin
      o_rd_data <= wr_data;
    end else begin
      o_rd_data <= shadow[i_rd_addr];
    end
  end

  assign o_shutdown_n = shadow[12][0];

`ifdef MAX7219_MONITOR_ERR_COUNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_cnt <= '0;
    end else if (commit_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_err_count = err_cnt;
`else
  assign o_err_count = 8'h00;
`endif

endmodule
